sha_msg_schedule: RTL and testbench
===================================

// Module: sha_msg_schedule
// PURPOSE
//  SHA-256 message-schedule generator. Drives the per-round w and k inputs of the round/compression datapath.
//  Accepts one 512-bit block as 16 serial 32-bit words, then emits W[0..63] with K[0..63], one round per handshake.
//  Sits between the block padder/loader and the round datapath.
// PARAMETERS
//  none: SHA-256 widths are fixed; localparam NUM_WORDS=16, NUM_ROUNDS=64, K ROM = 64 x 32-bit FIPS 180-4 constants
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  flush       in   1   synchronous abort: discard partial block/schedule, return to LOAD
//  blk_valid   in   1   blk_word valid
//  blk_ready   out  1   schedule accepts a word (combinational: state==LOAD && !flush)
//  blk_word    in   32  message word, word 0 (big-endian M[31:0] of block) first
//  w_valid     out  1   w/k/round valid (state==RUN)
//  w_ready     in   1   round datapath consumes current round
//  w           out  32  W[t]
//  k           out  32  K[t]
//  round       out  6   t, 0..63
//  w_first     out  1   w_valid && round==0 (datapath loads chaining state)
//  w_last      out  1   w_valid && round==63
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, word count=0, round=0, window win[0..15]=0.
//   Resulting output values: w=0, k=K[0]=0x428a2f98, w_valid/w_first/w_last=0, blk_ready=1 (unless flush).
//  Storage: 16x32 shift window win[0..15]. Invariant in RUN: win[j] = W[t+j]. w = win[0]; k = K[round] (comb ROM).
//  LOAD: each blk_valid&&blk_ready shifts blk_word into win[15] (win[i]<=win[i+1]) and increments count.
//   On the 16th accepted word: count<=0, round<=0, state<=RUN.
//   First w_valid occurs the cycle after the 16th word is accepted; win[0]=W0 at that point.
//  RUN: w_valid=1. On w_valid&&w_ready:
//   - win[i]<=win[i+1] for i=0..14; win[15]<=nw.
//   - nw = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32.
//   - s0(x)=ROTR7^ROTR18^SHR3; s1(x)=ROTR17^ROTR19^SHR10.
//   - nw is computed every round; it is unused after t=47 but harmless.
//   - round increments; when round==63 is accepted, state<=LOAD, round<=0.
//  Without w_ready the outputs hold stable: no shift, no round change.
//  Back-to-back blocks: blk_ready rises the cycle after round 63 is accepted; no overlap of load and run.
//  flush: next edge state<=LOAD, count<=0, round<=0; window contents are don't-care.
//   blk_ready is 0 while flush=1, so no word is captured in the flush cycle.
//   flush has priority over both handshakes in the same cycle.
//  blk_valid while in RUN is ignored (blk_ready=0). w_ready while in LOAD is ignored (w_valid=0).
//  rst_n asserted mid-load or mid-run: immediate return to reset values; the partial block is lost.
// TESTING
//  1 "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1.
//    -> W16=0x61626380, W17=0x000F0000, W63=0x12b1edeb.
//    -> k(0)=0x428a2f98, k(63)=0xc67178f2; w_first at t=0, w_last at t=63.
//  2 Timing: 16 words on consecutive cycles -> w_valid exactly 1 cycle after the 16th accept.
//    -> 64 consecutive rounds, then blk_ready=1 the next cycle.
//  3 Backpressure: random w_ready (~50%) on the "abc" block.
//    -> identical W/K sequence as test 1; w/k/round stable whenever w_ready=0.
//  4 Gapped input: blk_valid toggling on the "abc" block -> same schedule as test 1.
//    Two back-to-back blocks: the second block's W0..W15 appear unaltered as rounds 0..15.
//  5 flush: after 7 words, and again at round 30.
//    -> returns to LOAD with count=0; the next full block yields a correct schedule.
//    flush together with blk_valid -> word not accepted.
//  6 Async reset mid-run (round 20): outputs take reset values immediately; a fresh block then works.

Source files
------------

// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule generator.
// Loads one 512-bit block as 16 serial words into a 16-entry shift window,
// then emits W[0..63] together with K[0..63], one round per w handshake.
module sha_msg_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w,
  output logic [31:0] k,
  output logic [5:0]  round,
  output logic        w_first,
  output logic        w_last
);

  localparam int NUM_WORDS  = 16;
  localparam int NUM_ROUNDS = 64;

  localparam logic [31:0] K_ROM [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  round_q, round_d;
  logic [31:0] win_q [NUM_WORDS];
  logic [31:0] win_d [NUM_WORDS];
  logic [31:0] nw;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next-state logic: flush wins, otherwise LOAD shifts in block words and RUN shifts in new schedule words
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    win_d   = win_q;
    nw      = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    if (flush) begin
      state_d = LOAD;
      cnt_d   = 4'd0;
      round_d = 6'd0;
    end else if (state_q == LOAD) begin
      if (blk_valid) begin
        for (int i = 0; i < NUM_WORDS - 1; i++) win_d[i] = win_q[i+1];
        win_d[NUM_WORDS-1] = blk_word;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = RUN;
          cnt_d   = 4'd0;
          round_d = 6'd0;
        end
      end
    end else if (w_ready) begin
      for (int i = 0; i < NUM_WORDS - 1; i++) win_d[i] = win_q[i+1];
      win_d[NUM_WORDS-1] = nw;
      if (round_q == 6'd63) begin
        state_d = LOAD;
        round_d = 6'd0;
      end else begin
        round_d = round_q + 6'd1;
      end
    end
  end

  // State, counters and window registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      round_q <= 6'd0;
      for (int i = 0; i < NUM_WORDS; i++) win_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      for (int i = 0; i < NUM_WORDS; i++) win_q[i] <= win_d[i];
    end
  end

  assign blk_ready = (state_q == LOAD) && !flush;
  assign w_valid   = (state_q == RUN);
  assign w         = win_q[0];
  assign k         = K_ROM[round_q];
  assign round     = round_q;
  assign w_first   = w_valid && (round_q == 6'd0);
  assign w_last    = w_valid && (round_q == 6'd63);

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Testbench for sha_msg_schedule: a block-level SHA-256 schedule model
// (computes all 64 W words from the accepted block) checked against the
// DUT on every negative clock edge, plus literal "abc" pins.
module tb_sha_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blk_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w;
  logic [31:0] k;
  logic [5:0]  round;
  logic        w_first;
  logic        w_last;

  int total = 0;
  int bad   = 0;

  logic [31:0] kTab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Model state
  logic        mRun;
  int          mCnt;
  int          mRound;
  logic [31:0] mBlk [16];
  logic [31:0] mW   [64];

  // Captured DUT outputs for literal pins
  logic [31:0] capW [64];
  logic [31:0] capK [64];

  logic [31:0] abcBlk [16];
  logic [31:0] rndBlk [16];

  sha_msg_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w         (w),
    .k         (k),
    .round     (round),
    .w_first   (w_first),
    .w_last    (w_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: collect accepted words, expand the whole schedule, step rounds on handshakes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRun   = 1'b0;
      mCnt   = 0;
      mRound = 0;
    end else if (flush) begin
      mRun   = 1'b0;
      mCnt   = 0;
      mRound = 0;
    end else if (!mRun) begin
      if (blk_valid) begin
        mBlk[mCnt] = blk_word;
        mCnt++;
        if (mCnt == 16) begin
          for (int t = 0; t < 16; t++) mW[t] = mBlk[t];
          for (int t = 16; t < 64; t++)
            mW[t] = (rotr(mW[t-2], 17) ^ rotr(mW[t-2], 19) ^ (mW[t-2] >> 10))
                  + mW[t-7]
                  + (rotr(mW[t-15], 7) ^ rotr(mW[t-15], 18) ^ (mW[t-15] >> 3))
                  + mW[t-16];
          mRun   = 1'b1;
          mCnt   = 0;
          mRound = 0;
        end
      end
    end else if (w_ready) begin
      if (mRound == 63) begin
        mRun   = 1'b0;
        mRound = 0;
      end else begin
        mRound++;
      end
    end
  end

  // Compare process: check every output against the model mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("w_valid", {31'd0, w_valid}, {31'd0, mRun});
      checkOutput("blk_ready", {31'd0, blk_ready}, {31'd0, !mRun && !flush});
      if (mRun) begin
        checkOutput("round", {26'd0, round}, mRound);
        checkOutput("w", w, mW[mRound]);
        checkOutput("k", k, kTab[mRound]);
        checkOutput("w_first", {31'd0, w_first}, {31'd0, mRound == 0});
        checkOutput("w_last", {31'd0, w_last}, {31'd0, mRound == 63});
      end
    end
  end

  // Feed nWords of blk; gapped mode toggles blk_valid randomly
  task automatic applyStimulus(input logic [31:0] blk [16], input int nWords, input bit gapped);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < nWords && guard < 500) begin
      blk_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      blk_word  = blk[i];
      #1;
      acc = blk_valid && blk_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    blk_valid = 1'b0;
    if (i < nWords) begin
      bad++;
      total++;
      $display("[TB] FAIL load timeout: accepted %0d required %0d", i, nWords);
    end
  endtask

  // Consume rounds until round 63 is accepted, or stop (w_ready low) once stopRound is shown
  task automatic runRounds(input bit randomReady, input int stopRound);
    int guard = 0;
    bit done = 1'b0;
    bit lastAcc;
    while (!done && guard < 1000) begin
      if (stopRound >= 0 && w_valid && round == 6'(stopRound)) begin
        w_ready = 1'b0;
        return;
      end
      w_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      lastAcc = 1'b0;
      if (w_valid && w_ready) begin
        capW[round] = w;
        capK[round] = k;
        lastAcc = (round == 6'd63);
      end
      @(posedge clk);
      #1;
      if (lastAcc) done = 1'b1;
      guard++;
    end
    w_ready = 1'b0;
    if (!done) begin
      bad++;
      total++;
      $display("[TB] FAIL run timeout: round %0d required 63 accepted", round);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    blk_valid = 1'b0;
    blk_word  = 32'd0;
    w_ready   = 1'b0;
    for (int i = 0; i < 16; i++) abcBlk[i] = 32'd0;
    abcBlk[0]  = 32'h61626380;
    abcBlk[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) rndBlk[i] = $urandom;

    #8;
    checkOutput("reset w", w, 32'd0);
    checkOutput("reset k", k, 32'h428a2f98);
    checkOutput("reset w_valid", {31'd0, w_valid}, 32'd0);
    checkOutput("reset blk_ready", {31'd0, blk_ready}, 32'd1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1/2: abc block, consecutive words, w_ready=1");
    applyStimulus(abcBlk, 16, 1'b0);
    checkOutput("first valid latency", {31'd0, w_valid}, 32'd1);
    checkOutput("W0 abc", w, 32'h61626380);
    runRounds(1'b0, -1);
    checkOutput("blk_ready after 63", {31'd0, blk_ready}, 32'd1);
    checkOutput("w_valid after 63", {31'd0, w_valid}, 32'd0);
    checkOutput("W16 abc", capW[16], 32'h61626380);
    checkOutput("W17 abc", capW[17], 32'h000F0000);
    checkOutput("W63 abc", capW[63], 32'h12b1edeb);
    checkOutput("K0", capK[0], 32'h428a2f98);
    checkOutput("K63", capK[63], 32'hc67178f2);
    checkOutput("model W63", mW[63], 32'h12b1edeb);

    $display("[TB] test 3: backpressure");
    applyStimulus(abcBlk, 16, 1'b0);
    runRounds(1'b1, -1);
    checkOutput("W63 backpressure", capW[63], 32'h12b1edeb);

    $display("[TB] test 4: gapped input, back-to-back blocks");
    applyStimulus(abcBlk, 16, 1'b1);
    runRounds(1'b0, -1);
    applyStimulus(rndBlk, 16, 1'b0);
    runRounds(1'b1, -1);
    checkOutput("second block W15", capW[15], rndBlk[15]);

    $display("[TB] test 5: flush mid-load and mid-run");
    applyStimulus(rndBlk, 7, 1'b0);
    blk_valid = 1'b1;
    blk_word  = 32'hdeadbeef;
    flush     = 1'b1;
    #1;
    checkOutput("blk_ready during flush", {31'd0, blk_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    blk_valid = 1'b0;
    applyStimulus(abcBlk, 16, 1'b0);
    runRounds(1'b0, 30);
    flush   = 1'b1;
    w_ready = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    w_ready = 1'b0;
    checkOutput("w_valid after flush", {31'd0, w_valid}, 32'd0);
    checkOutput("round after flush", {26'd0, round}, 32'd0);
    applyStimulus(abcBlk, 16, 1'b0);
    runRounds(1'b0, -1);
    checkOutput("W63 after flush", capW[63], 32'h12b1edeb);

    $display("[TB] test 6: async reset mid-run");
    applyStimulus(rndBlk, 16, 1'b0);
    runRounds(1'b0, 20);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset w", w, 32'd0);
    checkOutput("mid-run reset k", k, 32'h428a2f98);
    checkOutput("mid-run reset round", {26'd0, round}, 32'd0);
    checkOutput("mid-run reset w_valid", {31'd0, w_valid}, 32'd0);
    checkOutput("mid-run reset blk_ready", {31'd0, blk_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    applyStimulus(abcBlk, 16, 1'b0);
    runRounds(1'b0, -1);
    checkOutput("W17 after reset", capW[17], 32'h000F0000);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
